adder_chain_sequencer: RTL

- Sequences a pipelined cascaded adder chain to sum vectors longer than the chain width.
- Issues the vector as back-to-back chunks of NUMBER_OF_ADDENDS addends, one chunk per clock.
- Tracks in-flight chunks through the chain latency and accumulates the partial sums into a wide signed accumulator.
- Presents the final sum with a valid/ready handshake; sits between the neuron weight/activation buffers and the activation stage.

---
 rtl/adder_chain_sequencer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/adder_chain_sequencer.sv
// Sequences a pipelined adder chain over N chunks and accumulates the partial sums.
// Define ADDER_CHAIN_SEQ_SATURATE_EN for a saturating accumulator with a sticky overflow flag.
module adder_chain_sequencer #(
    parameter int SUM_WIDTH       = 16,
    parameter int ACC_WIDTH       = 24,
    parameter int MAX_CHUNKS      = 16,
    parameter int CHUNK_IDX_WIDTH = $clog2(MAX_CHUNKS),
    parameter int CHAIN_LATENCY   = 6
) (
    input  logic                       clk_in,
    input  logic                       reset_i,
    input  logic                       start_i,
    input  logic [CHUNK_IDX_WIDTH:0]   num_chunks_i,
    output logic                       busy_o,
    output logic [CHUNK_IDX_WIDTH-1:0] chunk_idx_o,
    output logic                       chain_valid_o,
    input  logic [SUM_WIDTH-1:0]       chain_sum_i,
    output logic [ACC_WIDTH-1:0]       sum_o,
    output logic                       sum_valid_o,
    input  logic                       sum_ready_i,
    output logic                       overflow_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [CHUNK_IDX_WIDTH:0] MAX_N = (CHUNK_IDX_WIDTH+1)'(MAX_CHUNKS);

    state_t                     state, state_nxt;
    logic [CHUNK_IDX_WIDTH:0]   n_chunks, n_clamped;
    logic [CHUNK_IDX_WIDTH-1:0] chunk_idx;
    logic [ACC_WIDTH-1:0]       acc, acc_nxt;
    logic [CHAIN_LATENCY:0]     vld_pipe;
    logic                       start_acc, last_issue, drain_last, acc_en;

    assign n_clamped  = (num_chunks_i > MAX_N) ? MAX_N : num_chunks_i;
    assign start_acc  = (state == IDLE) && start_i;
    assign last_issue = ({1'b0, chunk_idx} == n_chunks - 1'b1);
    assign acc_en     = vld_pipe[CHAIN_LATENCY];

    // vld_pipe[k] is chain_valid_o delayed by k cycles; the top bit marks a live chain_sum_i.
    generate
        if (CHAIN_LATENCY > 0) begin : g_pipe
            logic [CHAIN_LATENCY:1] vld_q;
            always_ff @(posedge clk_in) begin
                if (reset_i) vld_q <= '0;
                else         vld_q <= vld_pipe[CHAIN_LATENCY-1:0];
            end
            assign vld_pipe = {vld_q, chain_valid_o};
            // Issues are contiguous, so the trailing edge of the valid train is the last result.
            assign drain_last = vld_pipe[CHAIN_LATENCY] & ~vld_pipe[CHAIN_LATENCY-1];
        end else begin : g_comb
            assign vld_pipe   = chain_valid_o;
            assign drain_last = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_i) state_nxt = (n_clamped == '0) ? DONE : ISSUE;
            ISSUE: if (last_issue) state_nxt = (CHAIN_LATENCY == 0) ? DONE : DRAIN;
            DRAIN: if (drain_last) state_nxt = DONE;
            DONE:  if (sum_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state != IDLE);
        chain_valid_o = (state == ISSUE);
        sum_valid_o   = (state == DONE);
    end

    always_ff @(posedge clk_in) begin
        if (reset_i) begin
            n_chunks  <= '0;
            chunk_idx <= '0;
            acc       <= '0;
        end else if (start_acc) begin
            n_chunks  <= n_clamped;
            chunk_idx <= '0;
            acc       <= '0;
        end else begin
            if (state == ISSUE && !last_issue) chunk_idx <= chunk_idx + 1'b1;
            if (acc_en) acc <= acc_nxt;
        end
    end

`ifdef ADDER_CHAIN_SEQ_SATURATE_EN
    logic [ACC_WIDTH:0] wide;
    logic               clamp, ovf;

    // One guard bit catches signed overflow; clamp toward the sign of the true result.
    always_comb begin
        wide    = {acc[ACC_WIDTH-1], acc} + (ACC_WIDTH+1)'(signed'(chain_sum_i));
        clamp   = (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]);
        acc_nxt = wide[ACC_WIDTH-1:0];
        if (clamp)
            acc_nxt = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end

    always_ff @(posedge clk_in) begin
        if (reset_i)               ovf <= 1'b0;
        else if (start_acc)        ovf <= 1'b0;
        else if (acc_en && clamp)  ovf <= 1'b1;
    end

    assign overflow_o = ovf;
`else
    always_comb acc_nxt = acc + ACC_WIDTH'(signed'(chain_sum_i));
    assign overflow_o = 1'b0;
`endif

    assign chunk_idx_o = chunk_idx;
    assign sum_o       = acc;
endmodule
